bus_request_arbiter: RTL and testbench

Parametrised, registered successor to the one-hot bus-source encoder. It takes N request lines and produces a registered binary select index, a one-hot grant and a valid flag for the shared bus mux. It replaces the ambiguous "index 0 on no/invalid input" behaviour with explicit arbitration:
- fixed-priority or round-robin mode
- grant hold (lock)
- saturating conflict statistics counter

---
 rtl/bus_request_arbiter.sv | 86 ++++++++
 tb/tb_bus_request_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bus_request_arbiter.sv
// Registered N-source bus arbiter: fixed-priority or round-robin selection, grant hold,
// and a saturating count of contended cycles.
module bus_request_arbiter #(
  parameter int N  = 32,
  parameter int W  = $clog2(N),
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [N-1:0]  req,
  input  logic          mode,
  input  logic          hold,
  input  logic          clr_stat,
  output logic [W-1:0]  sel,
  output logic [N-1:0]  grant,
  output logic          valid,
  output logic [CW-1:0] conflict_cnt
);

  logic [W-1:0] ptr;
  logic [W-1:0] g_lo;
  logic [W-1:0] g_rr;
  logic         found_rr;
  logic [W-1:0] win;
  logic [W-1:0] ptr_nxt;
  logic [N-1:0] grant_nxt;
  logic         any_req;
  logic         multi_req;
  logic         hold_ok;

  // Descending scans leave the lowest matching index in the result.
  always_comb begin
    g_lo     = '0;
    g_rr     = '0;
    found_rr = 1'b0;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) begin
        g_lo = W'(i-1);
        if (W'(i-1) >= ptr) begin
          g_rr     = W'(i-1);
          found_rr = 1'b1;
        end
      end
    end
  end

  always_comb begin
    win       = (mode && found_rr) ? g_rr : g_lo;
    ptr_nxt   = '0;
    if (mode && (win != W'(N-1)))
      ptr_nxt = win + 1'b1;
    grant_nxt      = '0;
    grant_nxt[win] = 1'b1;
    any_req   = |req;
    multi_req = |(req & (req - 1'b1));
    hold_ok   = hold && valid && req[sel];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sel   <= '0;
      grant <= '0;
      valid <= 1'b0;
      ptr   <= '0;
    end else if (hold_ok) begin
      sel   <= sel;
    end else if (!any_req) begin
      sel   <= '0;
      grant <= '0;
      valid <= 1'b0;
    end else begin
      sel   <= win;
      grant <= grant_nxt;
      valid <= 1'b1;
      ptr   <= ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (clr || clr_stat)
      conflict_cnt <= '0;
    else if (multi_req && (conflict_cnt != '1))
      conflict_cnt <= conflict_cnt + 1'b1;
  end

endmodule

// File: tb/tb_bus_request_arbiter.sv
// Directed and randomized checks of bus_request_arbiter against a rotation-based
// arbitration model.
module tb_bus_request_arbiter;
  localparam int N  = 32;
  localparam int W  = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          clr;
  logic [N-1:0]  req;
  logic          mode;
  logic          hold;
  logic          clr_stat;
  logic [W-1:0]  sel;
  logic [N-1:0]  grant;
  logic          valid;
  logic [CW-1:0] conflict_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int unsigned m_sel, m_ptr, m_cnt;
  bit          m_valid;

  always #5 clk = ~clk;

  bus_request_arbiter #(.N(N), .W(W), .CW(CW)) dut (
    .clk(clk), .clr(clr), .req(req), .mode(mode), .hold(hold), .clr_stat(clr_stat),
    .sel(sel), .grant(grant), .valid(valid), .conflict_cnt(conflict_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner is the first requester met while walking around the ring from the start index.
  task automatic model_edge(input logic [N-1:0] r, input bit m, input bit h, input bit cs,
                            input bit c);
    int unsigned start;
    if (c) begin
      m_sel = 0; m_ptr = 0; m_cnt = 0; m_valid = 0;
      return;
    end
    if (cs) m_cnt = 0;
    else if ($countones(r) >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
    if (h && m_valid && r[m_sel]) return;
    if (r == '0) begin
      m_valid = 0; m_sel = 0;
      return;
    end
    start = m ? m_ptr : 0;
    for (int unsigned j = 0; j < N; j++) begin
      if (r[(start + j) % N]) begin
        m_sel = (start + j) % N;
        break;
      end
    end
    m_valid = 1;
    m_ptr   = m ? (m_sel + 1) % N : 0;
  endtask

  task automatic step(input logic [N-1:0] r, input bit m, input bit h, input bit cs,
                      input bit c);
    logic [N-1:0] exp_grant;
    req = r; mode = m; hold = h; clr_stat = cs; clr = c;
    @(posedge clk);
    model_edge(r, m, h, cs, c);
    #1;
    exp_grant = m_valid ? (N'(1) << m_sel) : '0;
    check("sel", 64'(sel), 64'(m_sel));
    check("grant", 64'(grant), 64'(exp_grant));
    check("valid", 64'(valid), 64'(m_valid));
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
  endtask

  task automatic reset2();
    step('1, 1'b0, 1'b1, 1'b0, 1'b1);
    step('1, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    logic [N-1:0] r;
    int unsigned rr_exp [4] = '{2, 4, 31, 2};
    m_sel = 0; m_ptr = 0; m_cnt = 0; m_valid = 0;
    req = '0; mode = 0; hold = 0; clr_stat = 0; clr = 1;

    // Reset with everything asserted, then first round-robin grant.
    reset2();
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_cnt", 64'(conflict_cnt), 64'd0);
    step(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rr_first", 64'(sel), 64'd0);

    // One-hot sweep keeps the legacy encoder mapping.
    reset2();
    for (int k = 0; k < N; k++) begin
      step(N'(1) << k, 1'b0, 1'b0, 1'b0, 1'b0);
      check("onehot_sel", 64'(sel), 64'(k));
      check("onehot_cnt", 64'(conflict_cnt), 64'd0);
    end
    step('0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_grant", 64'(grant), 64'd0);

    // Fixed priority.
    reset2();
    for (int k = 0; k < 3; k++) begin
      step(32'h8000_0014, 1'b0, 1'b0, 1'b0, 1'b0);
      check("fixed_sel", 64'(sel), 64'd2);
    end
    check("fixed_cnt", 64'(conflict_cnt), 64'd3);

    // Round robin wrap.
    reset2();
    for (int k = 0; k < 4; k++) begin
      step(32'h8000_0014, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rr_seq", 64'(sel), 64'(rr_exp[k]));
    end

    // Hold, release on dropped request, clr mid-hold.
    reset2();
    step(32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_init", 64'(sel), 64'd4);
    for (int k = 0; k < 3; k++) begin
      step(32'h12, 1'b1, 1'b1, 1'b0, 1'b0);
      check("hold_keep", 64'(sel), 64'd4);
    end
    step(32'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    check("hold_release", 64'(sel), 64'd1);
    step(32'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'h02, 1'b1, 1'b1, 1'b0, 1'b1);
    check("hold_clr_valid", 64'(valid), 64'd0);
    check("hold_clr_grant", 64'(grant), 64'd0);

    // Counter saturation and clear priority.
    reset2();
    for (int k = 0; k < 300; k++) step(32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sat_cnt", 64'(conflict_cnt), 64'd255);
    step(32'h3, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_stat_cnt", 64'(conflict_cnt), 64'd0);
    step(32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    check("after_clr_stat", 64'(conflict_cnt), 64'd1);

    // Randomized traffic of varying density.
    reset2();
    for (int k = 0; k < 2000; k++) begin
      case ($urandom_range(3))
        0: r = '0;
        1: r = N'(1) << $urandom_range(N-1);
        2: r = $urandom & $urandom & $urandom;
        default: r = $urandom;
      endcase
      step(r, 1'($urandom_range(1)), ($urandom_range(3) == 0),
           ($urandom_range(40) == 0), ($urandom_range(80) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
